// File: rtl/bram_dp_if.sv
// rtl/bram_dp_if.sv - bus bundle for the two bram_dp access ports
interface bram_dp_if #(
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  // Port 0
  logic              EN0;
  logic [NB-1:0]     WE0;
  logic [31:0]       A0;
  logic [DATA_W-1:0] Di0;
  logic [DATA_W-1:0] Do0;
  logic              Dv0;

  // Port 1
  logic              EN1;
  logic [NB-1:0]     WE1;
  logic [31:0]       A1;
  logic [DATA_W-1:0] Di1;
  logic [DATA_W-1:0] Do1;
  logic              Dv1;

  // Clear sequencer owns the array while high
  logic              BUSY;

  modport master (
    output EN0, WE0, A0, Di0,
    output EN1, WE1, A1, Di1,
    input  Do0, Dv0, Do1, Dv1, BUSY
  );

  modport slave (
    input  EN0, WE0, A0, Di0,
    input  EN1, WE1, A1, Di1,
    output Do0, Dv0, Do1, Dv1, BUSY
  );
endinterface

// File: rtl/bram_dp.sv
// rtl/bram_dp.sv - true dual-port byte-writable RAM with post-reset clear sequencer
module bram_dp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       CLK,
  input  logic       RSTN,
  bram_dp_if.slave   bus
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              clr_we;
  logic              busy;

  logic              acc0, acc1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] rd0_d, rd1_d;

  logic              s1_dv0_q, s1_dv1_q;
  logic [DATA_W-1:0] s1_do0_q, s1_do1_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Upper address bits are deliberately ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.A0[31:ADDR_W], bus.A1[31:ADDR_W], cnt_q[ADDR_W]};

  assign busy     = (state_q == CLEAR);
  assign bus.BUSY = busy;

  assign acc0  = bus.EN0 & ~busy;
  assign acc1  = bus.EN1 & ~busy;
  assign addr0 = bus.A0[ADDR_W-1:0];
  assign addr1 = bus.A1[ADDR_W-1:0];

  // Clear sequencer next state: sweep every word once, then park in READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  // Sequencer state register; reset restarts the sweep from word 0
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array writes: port 1 first so that port 0 overrides any byte both ports write
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt_q[ADDR_W-1:0]] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (acc1 && bus.WE1[b]) begin
          mem[addr1][b*8 +: 8] <= bus.Di1[b*8 +: 8];
        end
      end
      for (int b = 0; b < NB; b++) begin
        if (acc0 && bus.WE0[b]) begin
          mem[addr0][b*8 +: 8] <= bus.Di0[b*8 +: 8];
        end
      end
    end
  end

  // Read-first data: old word for accepted accesses, zero otherwise
  always_comb begin
    rd0_d = '0;
    rd1_d = '0;
    if (acc0) rd0_d = mem[addr0];
    if (acc1) rd1_d = mem[addr1];
  end

  // First read stage, captured at the accepting edge
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_dv0_q <= 1'b0;
      s1_dv1_q <= 1'b0;
      s1_do0_q <= '0;
      s1_do1_q <= '0;
    end else begin
      s1_dv0_q <= acc0;
      s1_dv1_q <= acc1;
      s1_do0_q <= rd0_d;
      s1_do1_q <= rd1_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_dv0_q, s2_dv1_q;
      logic [DATA_W-1:0] s2_do0_q, s2_do1_q;

      // Second read stage delays data and valid together by one cycle
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          s2_dv0_q <= 1'b0;
          s2_dv1_q <= 1'b0;
          s2_do0_q <= '0;
          s2_do1_q <= '0;
        end else begin
          s2_dv0_q <= s1_dv0_q;
          s2_dv1_q <= s1_dv1_q;
          s2_do0_q <= s1_do0_q;
          s2_do1_q <= s1_do1_q;
        end
      end

      assign bus.Do0 = s2_do0_q;
      assign bus.Dv0 = s2_dv0_q;
      assign bus.Do1 = s2_do1_q;
      assign bus.Dv1 = s2_dv1_q;
    end else begin : g_lat1
      assign bus.Do0 = s1_do0_q;
      assign bus.Dv0 = s1_dv0_q;
      assign bus.Do1 = s1_do1_q;
      assign bus.Dv1 = s1_dv1_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp.sv
// tb/tb_bram_dp.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances in lockstep
module tb_bram_dp;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  bram_dp_if #(.DATA_W(32)) bus_a ();
  bram_dp_if #(.DATA_W(32)) bus_b ();

  bram_dp #(.DATA_W(32), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut_a (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus_a)
  );

  bram_dp #(.DATA_W(32), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut_b (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus_b)
  );

  exp_t        qa0[$], qa1[$], qb0[$], qb1[$];
  logic [31:0] model [DEPTH];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t peek(input exp_t q[$]);
    exp_t e;
    e.d   = '0;
    e.due = -1;
    if (q.size() != 0) e = q[0];
    return e;
  endfunction

  task automatic chk_out(input string tag, input logic dv, input logic [31:0] dout,
                         input exp_t fr, output bit hit);
    hit = (fr.due == cyc);
    chk({tag, "_dv"}, {31'b0, dv}, {31'b0, hit});
    chk({tag, "_do"}, dout, hit ? fr.d : 32'h0);
  endtask

  always @(negedge CLK) begin
    bit h;
    if (mon_en) begin
      chk_out("a0", bus_a.Dv0, bus_a.Do0, peek(qa0), h);
      if (h) void'(qa0.pop_front());
      chk_out("a1", bus_a.Dv1, bus_a.Do1, peek(qa1), h);
      if (h) void'(qa1.pop_front());
      chk_out("b0", bus_b.Dv0, bus_b.Do0, peek(qb0), h);
      if (h) void'(qb0.pop_front());
      chk_out("b1", bus_b.Dv1, bus_b.Do1, peek(qb1), h);
      if (h) void'(qb1.pop_front());
    end
  end

  task automatic set_bus(input bit e0, input logic [3:0] w0, input int a0, input logic [31:0] d0,
                         input bit e1, input logic [3:0] w1, input int a1, input logic [31:0] d1);
    logic [31:0] fa0, fa1;
    fa0 = ($urandom() << AW) | 32'(a0);
    fa1 = ($urandom() << AW) | 32'(a1);
    bus_a.EN0 = e0; bus_a.WE0 = w0; bus_a.A0 = fa0; bus_a.Di0 = d0;
    bus_a.EN1 = e1; bus_a.WE1 = w1; bus_a.A1 = fa1; bus_a.Di1 = d1;
    bus_b.EN0 = e0; bus_b.WE0 = w0; bus_b.A0 = fa0; bus_b.Di0 = d0;
    bus_b.EN1 = e1; bus_b.WE1 = w1; bus_b.A1 = fa1; bus_b.Di1 = d1;
  endtask

  task automatic idle_bus();
    set_bus(0, 4'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);
  endtask

  // One accepted cycle: push read-first expectations, update the model, take the edge
  task automatic drive(input bit e0, input logic [3:0] w0, input int a0, input logic [31:0] d0,
                       input bit e1, input logic [3:0] w1, input int a1, input logic [31:0] d1);
    logic [31:0] r0, r1;
    r0 = model[a0];
    r1 = model[a1];
    set_bus(e0, w0, a0, d0, e1, w1, a1, d1);
    if (e0) begin
      qa0.push_back('{d: r0, due: cyc + 1});
      qb0.push_back('{d: r0, due: cyc + 2});
    end
    if (e1) begin
      qa1.push_back('{d: r1, due: cyc + 1});
      qb1.push_back('{d: r1, due: cyc + 2});
    end
    for (int b = 0; b < 4; b++)
      if (e1 && w1[b]) model[a1][b*8 +: 8] = d1[b*8 +: 8];
    for (int b = 0; b < 4; b++)
      if (e0 && w0[b]) model[a0][b*8 +: 8] = d0[b*8 +: 8];
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycles(input int n);
    idle_bus();
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic junk_cycle();
    set_bus(1, 4'hF, int'($urandom_range(DEPTH - 1)), $urandom(),
            1, 4'hF, int'($urandom_range(DEPTH - 1)), $urandom());
    @(posedge CLK); #1;
  endtask

  // Count edges until BUSY drops, hammering both ports with writes meanwhile
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (bus_a.BUSY === 1'b1 && n < 100) begin
      junk_cycle();
      n++;
    end
    idle_bus();
    chk(tag, 32'(n), 32'd16);
    chk({tag, "_b"}, {31'b0, bus_b.BUSY}, 32'd0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < DEPTH; i++) drive(1, 4'h0, i, 32'h0, 1, 4'h0, DEPTH - 1 - i, 32'h0);
    idle_cycles(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_bus();
    RSTN   = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("busy_rst_a", {31'b0, bus_a.BUSY}, 32'd1);
    chk("busy_rst_b", {31'b0, bus_b.BUSY}, 32'd1);

    // Post-reset clear
    RSTN = 1'b1;
    wait_clear("clear_len");
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    read_all_zero();

    // Byte-enable merge
    drive(1, 4'hF, 5, 32'hDEADBEEF, 0, 4'h0, 0, 32'h0);
    drive(1, 4'b0101, 5, 32'h11223344, 0, 4'h0, 0, 32'h0);
    drive(0, 4'h0, 0, 32'h0, 1, 4'h0, 5, 32'h0);

    // Same-address collision, port 0 wins shared bytes
    drive(1, 4'b0011, 3, 32'hAAAAAAAA, 1, 4'b0110, 3, 32'h55555555);
    drive(1, 4'h0, 3, 32'h0, 1, 4'h0, 3, 32'h0);

    // Read-first across ports
    drive(1, 4'hF, 7, 32'h1, 0, 4'h0, 0, 32'h0);
    drive(1, 4'hF, 7, 32'h2, 1, 4'h0, 7, 32'h0);
    drive(0, 4'h0, 0, 32'h0, 1, 4'h0, 7, 32'h0);
    idle_cycles(2);

    // Back-to-back reads for latency alignment
    drive(1, 4'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);
    drive(1, 4'h0, 1, 32'h0, 0, 4'h0, 0, 32'h0);
    drive(1, 4'h0, 2, 32'h0, 0, 4'h0, 0, 32'h0);
    idle_cycles(4);

    // Random mixed traffic on a small address window to force collisions
    repeat (80) begin
      drive(bit'($urandom_range(1)), 4'($urandom_range(15)), int'($urandom_range(7)), $urandom(),
            bit'($urandom_range(1)), 4'($urandom_range(15)), int'($urandom_range(7)), $urandom());
    end
    idle_cycles(4);

    // Reset pulsed in the middle of a clear
    RSTN = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    repeat (9) junk_cycle();
    RSTN = 1'b0;
    #1;
    chk("busy_mid_a", {31'b0, bus_a.BUSY}, 32'd1);
    repeat (2) junk_cycle();
    chk("busy_hold_a", {31'b0, bus_a.BUSY}, 32'd1);
    chk("busy_hold_b", {31'b0, bus_b.BUSY}, 32'd1);
    RSTN = 1'b1;
    wait_clear("clear_len2");
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    read_all_zero();

    chk("qa0_left", 32'(qa0.size()), 32'd0);
    chk("qa1_left", 32'(qa1.size()), 32'd0);
    chk("qb0_left", 32'(qb0.size()), 32'd0);
    chk("qb1_left", 32'(qb1.size()), 32'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
